// File: rtl/ram8_pkg.sv
// Shared types and constants for the 8x16 RAM burst front-end.
package ram8_pkg;

   localparam int unsigned RAM8_WIDTH = 16;
   localparam int unsigned RAM8_AW    = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2,
      StDrain = 2'd3
   } state_e;

endpackage

// File: rtl/ram8_burst_ctrl_burst_counter.sv
// Loadable address/beat counter; the address wraps naturally at 2**AW.
module burst_counter
   import ram8_pkg::*;
#(
   parameter int unsigned AW = RAM8_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] start,
   input  logic [AW-1:0] len,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [AW-1:0] addr_q;
   logic [AW-1:0] beats_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         beats_q <= '0;
      end else if (load) begin
         addr_q  <= start;
         beats_q <= len;
      end else if (step) begin
         addr_q  <= addr_q + AW'(1);
         beats_q <= beats_q - AW'(1);
      end
   end

   assign addr = addr_q;
   assign last = (beats_q == '0);

endmodule

// File: rtl/ram8_burst_ctrl.sv
// Valid/ready burst front-end for the 8x16 RAM with a one-entry read buffer.
module ram8_burst_ctrl
   import ram8_pkg::*;
#(
   parameter int unsigned WIDTH = RAM8_WIDTH,
   parameter int unsigned AW    = RAM8_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [AW-1:0]    req_addr,
   input  logic [AW-1:0]    req_len,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   input  logic             rd_ready,
   output logic             busy,
   output logic [WIDTH-1:0] ram_in,
   output logic             ram_load,
   output logic [AW-1:0]    ram_address,
   input  logic [WIDTH-1:0] ram_out
);

   state_e           state_q;
   logic             rd_valid_q;
   logic [WIDTH-1:0] rd_data_q;

   logic          cnt_load;
   logic          cnt_step;
   logic          wr_beat;
   logic          rd_capture;
   logic [AW-1:0] cur_addr;
   logic          cnt_last;

   assign cnt_load   = (state_q == StIdle) && req_valid;
   assign wr_beat    = (state_q == StWrite) && wr_valid;
   // The buffer is free when empty or being drained in this same cycle.
   assign rd_capture = (state_q == StRead) && (!rd_valid_q || rd_ready);
   assign cnt_step   = wr_beat || rd_capture;

   burst_counter #(
      .AW (AW)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .start (req_addr),
      .len   (req_len),
      .step  (cnt_step),
      .addr  (cur_addr),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  state_q <= req_write ? StWrite : StRead;
               end
            end
            StWrite: begin
               if (wr_valid && cnt_last) begin
                  state_q <= StIdle;
               end
            end
            StRead: begin
               if (rd_capture) begin
                  rd_data_q  <= ram_out;
                  rd_valid_q <= 1'b1;
                  if (cnt_last) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (rd_valid_q && rd_ready) begin
                  rd_valid_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Gated with rst_n so nothing is offered while reset is held.
   assign req_ready   = (state_q == StIdle) && rst_n;
   assign wr_ready    = (state_q == StWrite);
   assign busy        = (state_q != StIdle);
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign ram_in      = wr_data;
   assign ram_load    = wr_beat;
   assign ram_address = cur_addr;

endmodule
